xge_rx_pkt_reader: RTL

- Drains received frames from the 10GE MAC receive packet interface (pkt_rx_*), one frame at a time, in the clk_156m25 domain.
- Buffers the MAC's 1-cycle read latency in a small FIFO and re-emits frames on a valid/ready stream with per-frame byte length and error status.
- Maintains frame, error and protocol-error counters.
- Sits directly downstream of the MAC receive side and feeds the packet sink / scoreboard-facing logic.

---
 rtl/xge_rx_pkg.sv | 22 ++
 rtl/xge_rx_fifo.sv | 61 ++++++
 rtl/xge_rx_pkt_reader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/xge_rx_pkg.sv
// Shared types and constants for the 10GE receive packet reader.
package xge_rx_pkg;

  localparam int XGE_WORD_BYTES = 8;
  localparam int XGE_LEN_W      = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    GAP  = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic [63:0]          data;
    logic                 sop;
    logic                 eop;
    logic [2:0]           mod;
    logic                 err;
    logic [XGE_LEN_W-1:0] len;
  } rx_word_t;

endpackage

// File: rtl/xge_rx_fifo.sv
// DEPTH-entry first-word-fall-through FIFO of rx_word_t with occupancy output.
module xge_rx_fifo
  import xge_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  rx_word_t                 push_word_i,
  input  logic                     pop_i,
  output rx_word_t                 head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  rx_word_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is only legal when the same cycle frees the head.
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_word_i;
  end

endmodule

// File: rtl/xge_rx_pkt_reader.sv
// Drains MAC rx frames into a FWFT stream with length/error status and statistics.
// Define XGE_RX_LEN_CHECK_EN to fold MIN_LEN/MAX_LEN violations into out_err.
module xge_rx_pkt_reader
  import xge_rx_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 32
) (
  input  logic              clk_156m25,
  input  logic              reset_156m25_n,
  input  logic              pkt_rx_avail,
  output logic              pkt_rx_ren,
  input  logic [63:0]       pkt_rx_data,
  input  logic              pkt_rx_val,
  input  logic              pkt_rx_sop,
  input  logic              pkt_rx_eop,
  input  logic [2:0]        pkt_rx_mod,
  input  logic              pkt_rx_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [2:0]        out_mod,
  output logic              out_err,
  output logic [13:0]       out_len,
  output logic [CNT_W-1:0]  rx_frames,
  output logic [CNT_W-1:0]  rx_err_frames,
  output logic [CNT_W-1:0]  rx_proto_err
);

  localparam int OW = $clog2(DEPTH) + 1;
`ifdef XGE_RX_LEN_CHECK_EN
  localparam logic LEN_CHECK = 1'b1;
`else
  localparam logic LEN_CHECK = 1'b0;
`endif
  localparam logic [XGE_LEN_W-1:0] MIN_L     = XGE_LEN_W'(MIN_LEN);
  localparam logic [XGE_LEN_W-1:0] MAX_L     = XGE_LEN_W'(MAX_LEN);
  localparam logic [3:0]           WORD_INC  = 4'(XGE_WORD_BYTES);
  localparam logic [OW:0]          DEPTH_CNT = (OW+1)'(DEPTH);

  function automatic logic [XGE_LEN_W-1:0] sat_add(input logic [XGE_LEN_W-1:0] base,
                                                   input logic [3:0]           inc);
    logic [XGE_LEN_W:0] sum;
    sum = {1'b0, base} + {{(XGE_LEN_W-3){1'b0}}, inc};
    return sum[XGE_LEN_W] ? {XGE_LEN_W{1'b1}} : sum[XGE_LEN_W-1:0];
  endfunction

  rx_state_e             state_q, state_d;
  logic                  ren_q;
  logic                  in_frame_q, in_frame_d;
  logic [XGE_LEN_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]      frames_q, frames_d;
  logic [CNT_W-1:0]      err_frames_q, err_frames_d;
  logic [CNT_W-1:0]      proto_q, proto_d;

  rx_word_t              push_word, head, head_vis;
  logic [OW-1:0]         occ;
  logic [OW:0]           occ_resv;
  logic                  fifo_empty, fifo_full;
  logic                  push, pop, drop, ren;
  logic                  orphan, resop, len_bad;
  logic [3:0]            eff_mod, inc;
  logic [XGE_LEN_W-1:0]  cur_len;

  // Read enable: ren_q reserves a slot for the word still in flight from the MAC.
  assign occ_resv = {1'b0, occ} + {{OW{1'b0}}, ren_q};
  assign ren = (state_q == READ) & ~(pkt_rx_val & pkt_rx_eop) & (occ_resv < DEPTH_CNT);
  assign pkt_rx_ren = ren;

  assign eff_mod = (pkt_rx_mod == 3'd0) ? WORD_INC : {1'b0, pkt_rx_mod};
  assign inc     = pkt_rx_eop ? eff_mod : WORD_INC;
  assign cur_len = sat_add(pkt_rx_sop ? '0 : acc_q, inc);
  assign len_bad = (cur_len < MIN_L) | (cur_len > MAX_L);
  assign orphan  = pkt_rx_val & ~pkt_rx_sop & ~in_frame_q;
  assign resop   = pkt_rx_val &  pkt_rx_sop &  in_frame_q;

  always_comb begin
    push_word      = '0;
    push_word.data = pkt_rx_data;
    push_word.sop  = pkt_rx_sop;
    push_word.eop  = pkt_rx_eop;
    push_word.mod  = pkt_rx_mod;
    push_word.err  = pkt_rx_eop & (pkt_rx_err | orphan | (LEN_CHECK & len_bad));
    push_word.len  = cur_len;
  end

  assign pop  = out_ready & ~fifo_empty;
  assign push = pkt_rx_val & (~fifo_full | (pop & ren_q));
  assign drop = pkt_rx_val & ~push;

  xge_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_156m25),
    .rst_ni      (reset_156m25_n),
    .push_i      (push),
    .push_word_i (push_word),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (occ)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pkt_rx_avail) state_d = READ;
      READ:    if (pkt_rx_val & pkt_rx_eop) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d        = acc_q;
    in_frame_d   = in_frame_q;
    if (pkt_rx_val) begin
      acc_d      = pkt_rx_eop ? '0 : cur_len;
      in_frame_d = ~pkt_rx_eop;
    end
    // Frame statistics follow the stream side so they match what downstream saw.
    frames_d     = frames_q + CNT_W'(pop & head.eop);
    err_frames_d = err_frames_q + CNT_W'(pop & head.eop & head.err);
    proto_d      = proto_q + CNT_W'(resop) + CNT_W'(orphan) + CNT_W'(drop);
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state_q      <= IDLE;
      ren_q        <= 1'b0;
      in_frame_q   <= 1'b0;
      acc_q        <= '0;
      frames_q     <= '0;
      err_frames_q <= '0;
      proto_q      <= '0;
    end else begin
      state_q      <= state_d;
      ren_q        <= ren;
      in_frame_q   <= in_frame_d;
      acc_q        <= acc_d;
      frames_q     <= frames_d;
      err_frames_q <= err_frames_d;
      proto_q      <= proto_d;
    end
  end

  // FIFO storage is not reset, so hide the head while empty.
  assign head_vis      = fifo_empty ? '0 : head;
  assign out_valid     = ~fifo_empty;
  assign out_data      = head_vis.data;
  assign out_sop       = head_vis.sop;
  assign out_eop       = head_vis.eop;
  assign out_mod       = head_vis.mod;
  assign out_err       = head_vis.err;
  assign out_len       = head_vis.len;
  assign rx_frames     = frames_q;
  assign rx_err_frames = err_frames_q;
  assign rx_proto_err  = proto_q;

endmodule
